// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding a one-at-a-time ALU request/response sequencer (IDLE -> ISSUE -> HOLD).
// Optional build macro ALU_OPCODE_CHECK_EN: opcode 0 skips the ALU and returns an error response.
module alu_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [63:0] cmd_a,
   input  logic [63:0] cmd_b,
   input  logic [2:0]  cmd_op,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic [2:0]  alu_opcode,
   output logic        alu_en,
   input  logic [64:0] alu_y,
   input  logic        alu_ack,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [64:0] rsp_data,
   output logic        rsp_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  op;
   } cmd_t;

   state_t           r_state;
   state_t           w_next_state;
   cmd_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [63:0]      r_alu_a;
   logic [63:0]      r_alu_b;
   logic [2:0]       r_alu_opcode;
   logic [64:0]      r_rsp_data;
   cmd_t             w_head;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_capture;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_push    = cmd_valid && !w_full;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_capture = (r_state == ISSUE) && alu_ack;

   // Readiness comes from the registered count only, so a same-cycle pop never lets a full FIFO accept.
   assign cmd_ready = !w_full;

   // NOTE: the storage array carries no reset; emptiness is defined by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
`ifdef ALU_OPCODE_CHECK_EN
               w_next_state = (w_head.op == 3'd0) ? HOLD : ISSUE;
`else
               w_next_state = ISSUE;
`endif
            end
         end
         ISSUE: begin
            if (alu_ack) w_next_state = HOLD;
         end
         HOLD: begin
            if (rsp_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_opcode <= '0;
         r_rsp_data   <= '0;
      end else begin
         if (w_pop) begin
            r_alu_a      <= w_head.a;
            r_alu_b      <= w_head.b;
            r_alu_opcode <= w_head.op;
         end
         if (w_capture) begin
            r_rsp_data <= alu_y;
         end
`ifdef ALU_OPCODE_CHECK_EN
         else if (w_pop && (w_head.op == 3'd0)) begin
            r_rsp_data <= '0;
         end
`endif
      end
   end

`ifdef ALU_OPCODE_CHECK_EN
   logic r_rsp_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_err <= 1'b0;
      end else if (w_capture) begin
         r_rsp_err <= 1'b0;
      end else if (w_pop && (w_head.op == 3'd0)) begin
         r_rsp_err <= 1'b1;
      end
   end

   assign rsp_err = r_rsp_err;
`else
   assign rsp_err = 1'b0;
`endif

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_opcode = r_alu_opcode;
   assign alu_en     = (r_state == ISSUE);
   assign rsp_valid  = (r_state == HOLD);
   assign rsp_data   = r_rsp_data;

endmodule
